// File: rtl/cu_read_command_arbiter_if.sv
// Shared types for the CU read-command path and the requester-side
// handshake interface of cu_read_command_arbiter.
package cu_read_command_arbiter_pkg;

  localparam logic [7:0] DATA_READ_CONTROL_ID = 8'h10;

  typedef struct packed {
    logic        valid;
    logic [7:0]  cu_id;
    logic [7:0]  tag;
    logic [3:0]  command;
    logic [7:0]  size;
    logic [47:0] address;
  } CommandBufferLine;

  typedef struct packed {
    logic [7:0] cu_id;
    logic [7:0] tag;
  } ResponseCommand;

  typedef struct packed {
    logic           valid;
    ResponseCommand cmd;
    logic [7:0]     response;
  } ResponseBufferLine;

  typedef struct packed {
    logic alfull;
    logic full;
    logic empty;
    logic valid;
  } BufferStatus;

endpackage

// Handshake: requester i transfers a command in a cycle where
// request_valid_in[i] and request_ready_out[i] are both high. Ready is
// combinational, is at most one-hot, and never rises without the matching
// valid; a requester must hold valid and command stable until it sees ready.
interface cu_read_command_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import cu_read_command_arbiter_pkg::*;

  logic [NUM_REQ-1:0]             request_valid_in;
  CommandBufferLine [NUM_REQ-1:0] request_command_in;
  logic [NUM_REQ-1:0]             request_ready_out;

  modport master (
    output request_valid_in,
    output request_command_in,
    input  request_ready_out
  );

  modport slave (
    input  request_valid_in,
    input  request_command_in,
    output request_ready_out
  );

endinterface

// File: rtl/cu_read_command_arbiter.sv
// Round-robin arbiter sharing one read-command path between NUM_REQ read
// controls. Registers the granted command and tracks outstanding reads per
// requester from the returning responses.
// Optional feature: CU_READ_ARB_CREDIT_LIMIT_EN gates a requester once its
// outstanding count reaches MAX_OUTSTANDING.
module cu_read_command_arbiter
  import cu_read_command_arbiter_pkg::*;
#(
  parameter int         NUM_REQ         = 4,
  parameter logic [7:0] BASE_CU_ID      = DATA_READ_CONTROL_ID,
  parameter int         MAX_OUTSTANDING = 16
) (
  input  logic                     clock,
  input  logic                     rstn,
  input  logic                     enabled_in,
  cu_read_command_arbiter_if.slave req_if,
  input  ResponseBufferLine        read_response_in,
  input  BufferStatus              read_command_buffer_status,
  output CommandBufferLine         read_command_out,
  output logic [NUM_REQ-1:0][7:0]  outstanding_count_out,
  output logic                     arb_idle_out,
  output logic                     arb_error_out
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic                   enabled;
  logic [IDX_W-1:0]       last_grant;
  logic [7:0]             outstanding [NUM_REQ];

  logic [NUM_REQ-1:0]     eligible;
  logic [NUM_REQ-1:0]     ready;
  logic                   grant_found;
  logic [IDX_W-1:0]       grant_idx;
  CommandBufferLine       granted_cmd;

  logic [8:0]             resp_diff;
  logic                   resp_in_range;
  logic [IDX_W-1:0]       resp_idx;
  logic                   resp_dec_ok;
  logic                   resp_error;

  logic [NUM_REQ-1:0]     cnt_inc;
  logic [NUM_REQ-1:0]     cnt_dec;
  logic [NUM_REQ-1:0]     cnt_sat;
  logic                   sat_error;
  logic                   all_zero;

  logic                   unused_inputs;

  // Eligibility: valid, enabled and room downstream (plus a free credit).
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_if.request_valid_in[i] & enabled &
                    ~read_command_buffer_status.alfull;
`ifdef CU_READ_ARB_CREDIT_LIMIT_EN
      if (outstanding[i] >= 8'(MAX_OUTSTANDING)) eligible[i] = 1'b0;
`endif
    end
  end

  // Round-robin pick starting one past the last granted requester.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    ready       = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand     = (int'(last_grant) + off) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!grant_found && eligible[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
    if (grant_found) ready[grant_idx] = 1'b1;
  end

  assign req_if.request_ready_out = ready;

  // The requester's own valid bit is ignored; the registered line is valid.
  always_comb begin
    granted_cmd       = req_if.request_command_in[grant_idx];
    granted_cmd.valid = 1'b1;
  end

  // Map a response onto its requester and decide whether it is legitimate.
  always_comb begin
    resp_diff     = {1'b0, read_response_in.cmd.cu_id} - {1'b0, BASE_CU_ID};
    resp_in_range = read_response_in.valid && (resp_diff < 9'(NUM_REQ));
    resp_idx      = resp_diff[IDX_W-1:0];
    resp_dec_ok   = resp_in_range && (outstanding[resp_idx] != 8'd0);
    resp_error    = read_response_in.valid && !resp_dec_ok;
  end

  // Per-requester increment/decrement/saturation decisions and idle summary.
  always_comb begin
    all_zero = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_inc[i] = grant_found && (grant_idx == IDX_W'(i));
      cnt_dec[i] = resp_dec_ok && (resp_idx == IDX_W'(i));
      cnt_sat[i] = cnt_inc[i] && !cnt_dec[i] && (outstanding[i] == 8'hFF);
      if (outstanding[i] != 8'd0) all_zero = 1'b0;
      outstanding_count_out[i] = outstanding[i];
    end
    sat_error = |cnt_sat;
  end

  // Outstanding counters; a grant and a response on one requester cancel.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_REQ; i++) outstanding[i] <= 8'd0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (cnt_inc[i] && !cnt_dec[i] && !cnt_sat[i])
          outstanding[i] <= outstanding[i] + 8'd1;
        else if (cnt_dec[i] && !cnt_inc[i])
          outstanding[i] <= outstanding[i] - 8'd1;
      end
    end
  end

  // Enable register, grant pointer, command register and status flags.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      enabled          <= 1'b0;
      last_grant       <= IDX_W'(NUM_REQ - 1);
      read_command_out <= '0;
      arb_idle_out     <= 1'b1;
      arb_error_out    <= 1'b0;
    end else begin
      enabled <= enabled_in;
      if (grant_found) begin
        last_grant       <= grant_idx;
        read_command_out <= granted_cmd;
      end else begin
        read_command_out <= '0;
      end
      arb_idle_out  <= all_zero & ~(|req_if.request_valid_in) &
                       ~read_command_out.valid;
      arb_error_out <= arb_error_out | resp_error | sat_error;
    end
  end

  // Fields of the shared structs this block has no use for.
  assign unused_inputs = ^{read_response_in.cmd.tag, read_response_in.response,
                           read_command_buffer_status.full,
                           read_command_buffer_status.empty,
                           read_command_buffer_status.valid,
                           8'(MAX_OUTSTANDING)};

endmodule

// File: tb/tb_cu_read_command_arbiter.sv
// Bench for cu_read_command_arbiter: directed stimulus, a cycle-level
// behavioural model checked every cycle, and hand-computed literal checks.
module tb_cu_read_command_arbiter;
  import cu_read_command_arbiter_pkg::*;

  localparam int         NUM_REQ = 4;
  localparam logic [7:0] BASE    = DATA_READ_CONTROL_ID;
`ifdef CU_READ_ARB_CREDIT_LIMIT_EN
  localparam int         MAX_OUT = 2;
  localparam int         SAME_N  = 1;
`else
  localparam int         MAX_OUT = 16;
  localparam int         SAME_N  = 3;
`endif

  // ---------------- clock / reset ----------------
  logic clock;
  logic rstn;
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  logic                          enabled_in;
  ResponseBufferLine             read_response_in;
  BufferStatus                   read_command_buffer_status;
  CommandBufferLine              read_command_out;
  logic [NUM_REQ-1:0][7:0]       outstanding_count_out;
  logic                          arb_idle_out;
  logic                          arb_error_out;

  cu_read_command_arbiter_if #(.NUM_REQ(NUM_REQ)) req_if ();

  cu_read_command_arbiter #(
    .NUM_REQ(NUM_REQ), .BASE_CU_ID(BASE), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clock(clock),
    .rstn(rstn),
    .enabled_in(enabled_in),
    .req_if(req_if),
    .read_response_in(read_response_in),
    .read_command_buffer_status(read_command_buffer_status),
    .read_command_out(read_command_out),
    .outstanding_count_out(outstanding_count_out),
    .arb_idle_out(arb_idle_out),
    .arb_error_out(arb_error_out)
  );

  // ---------------- scoreboard counters ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_cmd(input string name, input CommandBufferLine act, input CommandBufferLine exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    CommandBufferLine c;
    @(posedge clock);
    #1;
    cyc++;
    for (int i = 0; i < NUM_REQ; i++) begin
      c         = '0;
      c.valid   = 1'(cyc & 1);
      c.cu_id   = 8'(int'(BASE) + i);
      c.tag     = 8'(cyc);
      c.command = 4'h1;
      c.size    = 8'd64;
      c.address = 48'(cyc * 16 + i);
      req_if.request_command_in[i] = c;
    end
  endtask

  task automatic set_resp(input bit v, input logic [7:0] id);
    ResponseBufferLine r;
    r              = '0;
    r.valid        = v;
    r.cmd.cu_id    = id;
    r.cmd.tag      = 8'hAA;
    r.response     = 8'h00;
    read_response_in = r;
  endtask

  // ---------------- behavioural model + compare ----------------
  bit               m_en;
  int               m_last;
  int               m_cnt [NUM_REQ];
  bit               m_err;
  bit               m_idle;
  CommandBufferLine m_cmd;

  function automatic bit credit_ok(input int c);
`ifdef CU_READ_ARB_CREDIT_LIMIT_EN
    return m_cnt[c] < MAX_OUT;
`else
    return c >= 0;
`endif
  endfunction

  always @(negedge clock) begin
    int                 g;
    int                 c;
    int                 d;
    int                 dec_i;
    bit                 nxt_idle;
    logic [NUM_REQ-1:0] exp_ready;
    CommandBufferLine   nc;
    if (!rstn) begin
      m_en = 0; m_last = NUM_REQ - 1; m_err = 0; m_idle = 1; m_cmd = '0;
      for (int i = 0; i < NUM_REQ; i++) m_cnt[i] = 0;
    end
    g = -1;
    for (int k = 1; k <= NUM_REQ; k++) begin
      c = (m_last + k) % NUM_REQ;
      if (g < 0 && req_if.request_valid_in[c] && m_en &&
          !read_command_buffer_status.alfull && credit_ok(c))
        g = c;
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("ready", 32'(req_if.request_ready_out), 32'(exp_ready));
    check_cmd("cmd_out", read_command_out, m_cmd);
    for (int i = 0; i < NUM_REQ; i++)
      check($sformatf("count%0d", i), 32'(outstanding_count_out[i]), 32'(m_cnt[i]));
    check("idle", 32'(arb_idle_out), 32'(m_idle));
    check("error", 32'(arb_error_out), 32'(m_err));
    if (rstn) begin
      nxt_idle = (req_if.request_valid_in == '0) && !m_cmd.valid;
      for (int i = 0; i < NUM_REQ; i++) if (m_cnt[i] != 0) nxt_idle = 0;
      dec_i = -1;
      if (read_response_in.valid) begin
        d = int'(read_response_in.cmd.cu_id) - int'(BASE);
        if (d >= 0 && d < NUM_REQ && m_cnt[d] > 0) dec_i = d;
        else m_err = 1;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (g == i && dec_i != i) begin
          if (m_cnt[i] == 255) m_err = 1;
          else m_cnt[i]++;
        end else if (dec_i == i && g != i) begin
          m_cnt[i]--;
        end
      end
      if (g >= 0) begin
        nc = req_if.request_command_in[g];
        nc.valid = 1'b1;
        m_cmd  = nc;
        m_last = g;
      end else begin
        m_cmd = '0;
      end
      m_idle = nxt_idle;
      m_en   = enabled_in;
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rstn = 1'b0;
    enabled_in = 1'b0;
    req_if.request_valid_in = '0;
    req_if.request_command_in = '0;
    read_command_buffer_status = '0;
    set_resp(0, 8'h00);
    repeat (3) step();

    // Reset values
    check("rst_ready", 32'(req_if.request_ready_out), 32'h0);
    check("rst_cmd_valid", 32'(read_command_out.valid), 32'h0);
    check("rst_idle", 32'(arb_idle_out), 32'h1);
    check("rst_error", 32'(arb_error_out), 32'h0);
    rstn = 1'b1;
    enabled_in = 1'b1;
    step();

    // All four valid: grants 0,1,2,3,0,...
    req_if.request_valid_in = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("rr_ready%0d", k), 32'(req_if.request_ready_out), 32'(4'b0001 << (k % 4)));
      if (k > 0) check($sformatf("rr_cmd_valid%0d", k), 32'(read_command_out.valid), 32'h1);
      step();
    end
    for (int i = 0; i < NUM_REQ; i++)
      check($sformatf("rr_count%0d", i), 32'(outstanding_count_out[i]), 32'd2);
    req_if.request_valid_in = '0;

    // Return all eight reads, then idle one cycle after counts reach zero
    for (int k = 0; k < 8; k++) begin
      set_resp(1, 8'(int'(BASE) + (k % 4)));
      step();
    end
    set_resp(0, 8'h00);
    check("drain_count0", 32'(outstanding_count_out[0]), 32'd0);
    check("drain_idle_pre", 32'(arb_idle_out), 32'h0);
    step();
    check("drain_idle", 32'(arb_idle_out), 32'h1);

    // Only requesters 1 and 3
    req_if.request_valid_in = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("alt_ready%0d", k), 32'(req_if.request_ready_out),
            (k % 2 == 0) ? 32'h2 : 32'h8);
      step();
    end

    // alfull high for 5 cycles, then resume from the saved pointer
    req_if.request_valid_in = 4'hF;
    read_command_buffer_status.alfull = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("alfull_ready%0d", k), 32'(req_if.request_ready_out), 32'h0);
      check($sformatf("alfull_cmd_valid%0d", k), 32'(read_command_out.valid), (k == 0) ? 32'h1 : 32'h0);
      step();
    end
    read_command_buffer_status.alfull = 1'b0;
    #1;
    check("resume_ready", 32'(req_if.request_ready_out), 32'h1);
    step();

    // Reset mid-operation clears counters and the command register at once
    rstn = 1'b0;
    #1;
    check("midrst_count1", 32'(outstanding_count_out[1]), 32'd0);
    check("midrst_cmd_valid", 32'(read_command_out.valid), 32'h0);
    check("midrst_ready", 32'(req_if.request_ready_out), 32'h0);
    step();
    step();
    rstn = 1'b1;
    req_if.request_valid_in = '0;
    step();

    // Same-cycle grant and response on requester 2
    req_if.request_valid_in = 4'b0100;
    repeat (SAME_N) step();
    check("same_count_pre", 32'(outstanding_count_out[2]), 32'(SAME_N));
    set_resp(1, 8'(int'(BASE) + 2));
    #1;
    check("same_ready", 32'(req_if.request_ready_out), 32'h4);
    step();
    set_resp(0, 8'h00);
    req_if.request_valid_in = '0;
    check("same_count", 32'(outstanding_count_out[2]), 32'(SAME_N));
    check("same_error", 32'(arb_error_out), 32'h0);

    // Out-of-range cu_id sets the sticky error
    set_resp(1, 8'(int'(BASE) + 7));
    step();
    set_resp(0, 8'h00);
    check("range_error", 32'(arb_error_out), 32'h1);
    repeat (3) step();
    check("range_error_sticky", 32'(arb_error_out), 32'h1);

    // Response for a requester at zero after reset
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    check("zero_error_pre", 32'(arb_error_out), 32'h0);
    set_resp(1, BASE);
    step();
    set_resp(0, 8'h00);
    check("zero_error", 32'(arb_error_out), 32'h1);

    rstn = 1'b0;
    step();
    rstn = 1'b1;
    step();
`ifdef CU_READ_ARB_CREDIT_LIMIT_EN
    // Credit ceiling: two grants, then blocked until one credit returns
    req_if.request_valid_in = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      #1;
      check($sformatf("credit_ready%0d", k), 32'(req_if.request_ready_out), 32'h1);
      step();
    end
    #1;
    check("credit_blocked", 32'(req_if.request_ready_out), 32'h0);
    step();
    set_resp(1, BASE);
    step();
    set_resp(0, 8'h00);
    #1;
    check("credit_regrant", 32'(req_if.request_ready_out), 32'h1);
    step();
    #1;
    check("credit_blocked2", 32'(req_if.request_ready_out), 32'h0);
`else
    // Saturation at 255 sets the error and holds the count
    req_if.request_valid_in = 4'b0010;
    repeat (255) step();
    check("sat_count", 32'(outstanding_count_out[1]), 32'd255);
    check("sat_error_pre", 32'(arb_error_out), 32'h0);
    #1;
    check("sat_ready", 32'(req_if.request_ready_out), 32'h2);
    step();
    check("sat_count_hold", 32'(outstanding_count_out[1]), 32'd255);
    check("sat_error", 32'(arb_error_out), 32'h1);
`endif
    req_if.request_valid_in = '0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cu_read_command_arbiter.md
# cu_read_command_arbiter

Round-robin arbiter sharing one CAPI read-command path between NUM_REQ read engine controls inside a compute unit. Accepts at most one CommandBufferLine per cycle via valid/ready, registers it onto the command buffer interface, and tracks outstanding reads per requester from returning read responses. Sits between the per-array read controls and the CU command buffer.

## Interface

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..8.
- BASE_CU_ID, DATA_READ_CONTROL_ID: cu_id of requester 0. Requester i owns cu_id BASE_CU_ID+i.
- MAX_OUTSTANDING, 16: per-requester outstanding-read ceiling; legal range 1..255. Used only under CU_READ_ARB_CREDIT_LIMIT_EN.

Ports:
- clock  in  1  clock; all logic on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- enabled_in  in  1  arbiter enable; registered once internally as `enabled`.
- request_valid_in  in  [NUM_REQ]  request i is presenting a command.
- request_command_in  in  [NUM_REQ] x CommandBufferLine  command from requester i; `.valid` field ignored.
- request_ready_out  out  [NUM_REQ]  combinational grant; transfer when valid&ready.
- read_response_in  in  ResponseBufferLine  read responses; `.cmd.cu_id` selects requester.
- read_command_buffer_status  in  BufferStatus  downstream command buffer status; `.alfull` used.
- read_command_out  out  CommandBufferLine  registered granted command.
- outstanding_count_out  out  [NUM_REQ] x 8  per-requester outstanding reads.
- arb_idle_out  out  1  no outstanding reads, no valid request, no command in flight.
- arb_error_out  out  1  sticky: response for a requester with zero outstanding, or cu_id outside range.

## Operation

- Requester i is eligible when request_valid_in[i], `enabled`, and ~read_command_buffer_status.alfull. Under CU_READ_ARB_CREDIT_LIMIT_EN, outstanding[i] < MAX_OUTSTANDING is also required.
- Round-robin: search starts at last_grant+1 mod NUM_REQ. The first eligible requester gets request_ready_out=1; all others get 0. At most one ready per cycle. Ready never asserts without the matching valid.
- On transfer:
  - read_command_out <= request_command_in[i] with .valid=1.
  - last_grant <= i.
  - outstanding[i] increments.
- No transfer: read_command_out <= 0, and last_grant holds.
- Response accounting: when read_response_in.valid is high, idx = cu_id - BASE_CU_ID.
  - idx in range and outstanding[idx] > 0: outstanding[idx] decrements.
  - Otherwise: no counter change, and arb_error_out sets.
- Grant and response on the same requester in the same cycle: net counter unchanged.
- Counters are 8-bit. An increment at 255 saturates and sets arb_error_out.
- Deassertion of enabled_in: ready drops after the 1-cycle enable register. Counters keep tracking responses.
- arb_idle_out = all outstanding zero & no request_valid_in & ~read_command_out.valid. It is registered.

## Timing

- Reset values:
  - read_command_out = 0.
  - outstanding counters = 0.
  - arb_idle_out = 1.
  - arb_error_out = 0.
  - last_grant = NUM_REQ-1, so requester 0 wins first.
- request_ready_out is combinational from registered state plus the current-cycle valid and alfull. It is 0 during reset.
- Latency: a command accepted in cycle N appears on read_command_out in cycle N+1, for exactly one cycle.
- Throughput: 1 command/cycle sustained while alfull is low.
- alfull is sampled in the same cycle as ready. When alfull rises, the next transfer is blocked that cycle. The previously registered command still issues; the buffer's alfull margin absorbs it.
- Response effect is visible on outstanding_count_out one cycle after read_response_in.valid.
- Reset mid-operation clears counters and the pointer immediately. In-flight responses arriving after reset flag arb_error_out.

## Configuration

- CU_READ_ARB_CREDIT_LIMIT_EN defined: a requester at MAX_OUTSTANDING is ineligible and skipped by round-robin until a response returns a credit.
- Not defined: there is no credit gating. Counters, saturation, and the error flag still operate.

## Test plan

- Reset, then all 4 requesters valid continuously with alfull=0 -> grants 0,1,2,3,0,... one per cycle; read_command_out.valid high every cycle from cycle 1 after the first ready.
- Only requesters 1 and 3 valid -> grants alternate 1,3,1,3; ready[0] and ready[2] stay 0.
- alfull held high 5 cycles while requesters are valid -> no ready for those cycles, read_command_out=0 from the cycle after. Resume on alfull low continues from the saved pointer.
- With the macro, MAX_OUTSTANDING=2, requester 0 alone valid, no responses -> 2 grants then ready[0]=0. One response with cu_id=BASE_CU_ID -> exactly one further grant.
- Grant to requester 2 and response for requester 2 in the same cycle with count 3 -> count stays 3. A response for cu_id BASE_CU_ID+7, or for a requester at count 0 -> arb_error_out=1 and sticky until reset.
- All counts return to 0 and valids drop -> arb_idle_out=1 the next cycle.
